// File: rtl/snapshot_capture_if.sv
// rtl/snapshot_capture_if.sv - sample/trigger inputs and BRAM/status outputs of the snapshot capture controller
//
// Purpose: bundles the control word, sample stream, trigger and the BRAM
// write port / status word so the controller takes a single bus port.
// Optional feature macro: SNAP_TRIG_OFFSET_EN (adds trig_offset).
//
// Signals:
//   ctrl_in     [31:0]      control word ([0] enable, [1] trig_src, [2] we_src)
//   din         [DATA_W-1:0] sample data
//   we                      external sample-valid qualifier
//   trig                    external trigger pulse
//   trig_offset [ADDR_W-1:0] post-trigger skip count (SNAP_TRIG_OFFSET_EN only)
//   bram_addr   [ADDR_W-1:0] BRAM write address
//   bram_data   [DATA_W-1:0] BRAM write data
//   bram_we                 BRAM write strobe
//   status_out  [31:0]      [31] done, [30] armed, [ADDR_W:0] samples written
//
// Modports: master drives the inputs (datapath / register side),
//           slave is the controller.

interface snapshot_capture_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
);
  logic [31:0]       ctrl_in;
  logic [DATA_W-1:0] din;
  logic              we;
  logic              trig;
`ifdef SNAP_TRIG_OFFSET_EN
  logic [ADDR_W-1:0] trig_offset;
`endif
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status_out;

  modport master (
    output ctrl_in, din, we, trig,
`ifdef SNAP_TRIG_OFFSET_EN
    output trig_offset,
`endif
    input  bram_addr, bram_data, bram_we, status_out
  );

  modport slave (
    input  ctrl_in, din, we, trig,
`ifdef SNAP_TRIG_OFFSET_EN
    input  trig_offset,
`endif
    output bram_addr, bram_data, bram_we, status_out
  );
endinterface

// File: rtl/snapshot_capture_ctrl.sv
// rtl/snapshot_capture_ctrl.sv - armed/triggered snapshot capture into BRAM with done/count status
//
// Purpose: arms on a rising edge of ctrl_in[0], waits for a trigger, then
// writes 2**ADDR_W qualified samples to consecutive BRAM addresses and
// reports done / armed / sample count in status_out.
// Optional feature macro: SNAP_TRIG_OFFSET_EN (skip trig_offset valid
// samples after the trigger before writing address 0).
//
// Ports:
//   user_clk  in   capture clock, rising edge
//   user_rst  in   asynchronous active-high reset
//   bus       snapshot_capture_if.slave (ctrl_in, din, we, trig,
//             [trig_offset], bram_addr, bram_data, bram_we, status_out)

module snapshot_capture_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic                user_clk,
  input  logic                user_rst,
  snapshot_capture_if.slave   bus
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
`ifdef SNAP_TRIG_OFFSET_EN
    , S_OFFSET
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_data_q, bram_data_d;
`ifdef SNAP_TRIG_OFFSET_EN
  logic [ADDR_W-1:0] off_q, off_d;
`endif

  logic arm_pulse;
  logic valid;
  logic trig_hit;
  logic capture_en;
  logic armed;

  assign arm_pulse = bus.ctrl_in[0] & ~en_q;
  assign valid     = bus.we | bus.ctrl_in[2];
  assign trig_hit  = bus.trig | bus.ctrl_in[1];

  always_comb begin
    state_d     = state_q;
    en_d        = bus.ctrl_in[0];
    count_d     = count_q;
    done_d      = done_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    capture_en  = 1'b0;
`ifdef SNAP_TRIG_OFFSET_EN
    off_d       = off_q;
`endif

    if (arm_pulse) begin
      // Re-arm wins over everything: no write and no trigger this cycle.
      state_d = S_ARMED;
      count_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (trig_hit) begin
`ifdef SNAP_TRIG_OFFSET_EN
            if (bus.trig_offset != '0) begin
              // The trigger-cycle sample already counts as one skipped sample.
              state_d = S_OFFSET;
              off_d   = valid ? (bus.trig_offset - 1'b1) : bus.trig_offset;
            end else begin
              state_d    = S_CAPTURE;
              capture_en = 1'b1;
            end
`else
            state_d    = S_CAPTURE;
            capture_en = 1'b1;
`endif
          end
        end
`ifdef SNAP_TRIG_OFFSET_EN
        S_OFFSET: begin
          if (off_q == '0) begin
            state_d    = S_CAPTURE;
            capture_en = 1'b1;
          end else if (valid) begin
            off_d = off_q - 1'b1;
          end
        end
`endif
        S_CAPTURE: capture_en = 1'b1;
        S_DONE:    done_d = 1'b1;
        default:   ;
      endcase

      if (capture_en && valid) begin
        bram_we_d   = 1'b1;
        bram_addr_d = count_q[ADDR_W-1:0];
        bram_data_d = bus.din;
        count_d     = count_q + 1'b1;
        if (count_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
`ifdef SNAP_TRIG_OFFSET_EN
      off_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      count_q     <= count_d;
      done_q      <= done_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
`ifdef SNAP_TRIG_OFFSET_EN
      off_q       <= off_d;
`endif
    end
  end

`ifdef SNAP_TRIG_OFFSET_EN
  assign armed = (state_q == S_ARMED) || (state_q == S_OFFSET) || (state_q == S_CAPTURE);
`else
  assign armed = (state_q == S_ARMED) || (state_q == S_CAPTURE);
`endif

  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_data  = bram_data_q;
  assign bus.status_out = {done_q, armed, {(29-ADDR_W){1'b0}}, count_q};

endmodule

// File: doc/snapshot_capture_ctrl.md
Name: snapshot_capture_ctrl

Overview:
- Consumes the 32-bit snapshot control word produced by the tx snapshot control software register (`user_data_out`, already in the `user_clk` domain).
- Arms on a software request, waits for a trigger, then writes a contiguous block of qualified samples into the snapshot BRAM.
- Reports a done flag and the sample count as a 32-bit status word for the companion status register.
- Sits between the tx datapath / ctrl register and the snapshot BRAM.

Parameters:
- DATA_W, 64, sample / BRAM data width
- ADDR_W, 10, BRAM address width; capture depth = 2**ADDR_W samples (legal 4..16)

Ports:
- user_clk  in  1  capture clock; all logic on rising edge
- user_rst  in  1  asynchronous, active-high reset
- ctrl_in  in  32  control word: [0] enable (rising edge arms), [1] trig_src (1 = trigger immediately), [2] we_src (1 = every cycle valid), [31:3] ignored
- din  in  DATA_W  sample data
- we  in  1  external sample-valid qualifier
- trig  in  1  external trigger pulse
- bram_addr  out  ADDR_W  BRAM write address
- bram_data  out  DATA_W  BRAM write data
- bram_we  out  1  BRAM write strobe
- status_out  out  32  [31] done, [30] armed/busy, [ADDR_W:0] samples written, other bits 0

Behaviour:
- Reset (async, active-high): state=IDLE; bram_addr=0; bram_data=0; bram_we=0; status_out=0; enable history register=0.
- Edge detect: arm_pulse = ctrl_in[0] & ~en_q, where en_q is ctrl_in[0] registered.
- valid = we | ctrl_in[2]; trig_hit = trig | ctrl_in[1].
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: arm_pulse -> ARMED; count cleared.
  - ARMED: trig_hit -> CAPTURE (see optional feature). If valid on the trigger cycle, that sample is written at address 0.
  - CAPTURE: each valid cycle writes din at address = count, then count+1. The cycle that writes address 2**ADDR_W-1 -> DONE. No wrap; no further writes.
  - DONE: holds; done=1.
- arm_pulse in any state (including mid-CAPTURE):
  - -> ARMED, count=0, done=0. Any write in that cycle is suppressed.
  - arm_pulse beats a simultaneous trig_hit: the trigger is ignored in that cycle.
- Falling edge of ctrl_in[0]: no effect; an in-progress capture completes.
- Write latency: bram_we/addr/data are registered one cycle after the qualifying din/valid. bram_we is exactly one cycle per sample.
- Status:
  - count field updates in the same cycle as the corresponding bram_we.
  - done asserts in the cycle after the last bram_we.
  - armed bit = 1 in ARMED and CAPTURE.
  - Full capture reads count = 2**ADDR_W, which is why the field is ADDR_W+1 bits.
- trig while not ARMED: ignored; no latching.

Optional Feature:
- Macro: SNAP_TRIG_OFFSET_EN
- Defined:
  - Adds input port trig_offset [ADDR_W-1:0] and a state OFFSET between ARMED and CAPTURE.
  - On trig_hit, offset counter loads trig_offset; valid samples decrement it with no writes.
  - The sample arriving when the counter is 0 is written at address 0.
  - trig_offset=0 behaves identically to the macro undefined.
  - arm_pulse aborts OFFSET exactly as it aborts CAPTURE.
- Undefined: no port, no OFFSET state; capture starts on the trigger cycle.

Test Plan:
- Reset mid-capture (user_rst high, count at 5) -> all outputs 0 immediately (async, before the next edge); IDLE; no bram_we until re-armed.
- ADDR_W=4, ctrl_in 0x0->0x7, din incrementing from 0x100 -> 16 bram_we pulses, addr 0..15, data 0x100..0x10F, first write 2 cycles after the arm edge. Then status_out=0x80000010 and stays.
- ctrl_in 0x1, we toggling 1/0, trig pulsed 3 cycles after arm -> first write carries the trigger-cycle din at addr 0. Only we=1 cycles written. Pre-trigger samples discarded.
- Mid-capture at count 7, ctrl_in toggled 0x1->0x0->0x1 -> falling edge changes nothing; rising edge returns to ARMED. status_out=0x40000000; next trigger restarts at addr 0.
- trig high in IDLE and in DONE -> no bram_we; status unchanged (0x0 / 0x80000010).
- SNAP_TRIG_OFFSET_EN, trig_offset=3, ctrl_in 0x7, din=k on cycle k, trig on cycle 10 -> samples 10..12 skipped; addr 0 receives din=13.
